flag_unit: RTL and testbench

Producer side of the N/V/Z condition-flag interface consumed by the branch/PC control logic. Holds the architectural flag register, decides per opcode which flags the instruction in EX updates, and drives the 3-bit flag bus `F[2:0]` = {N, V, Z} that the branch decision uses. It also bypasses same-cycle flag results, or, when bypass is disabled, raises a hazard so that a conditional branch in ID waits for the flags it depends on.

---
 rtl/flag_unit.sv | 131 +++++++++++++
 tb/tb_flag_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// -----------------------------------------------------------------------------
// flag_unit
//
// Producer side of the N/V/Z condition-flag interface used by branch/PC control.
// It holds the architectural flag register and decides, per EX opcode, which
// flags the EX instruction updates. It drives the flag bus F = {N, V, Z} that the
// branch decision reads. The bus either bypasses same-cycle EX results
// (FORWARD = 1), or shows only the registered value and raises flag_hazard so
// that a dependent conditional branch in ID waits one cycle (FORWARD = 0).
//
// Parameters
//   FORWARD      1: F carries this cycle's EX flag write combinationally
//                0: F is registered only; flag_hazard stalls dependent branches
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   ex_valid     EX holds a real (non-bubble) instruction
//   ex_opcode    opcode of the EX instruction
//   alu_result   ALU result of the EX instruction (drives Z)
//   alu_ovfl     ALU signed overflow of the EX instruction (drives V)
//   alu_neg      ALU result sign of the EX instruction (drives N)
//   stall        pipeline freeze, EX does not advance
//   flush        EX instruction is squashed
//   hlt          processor halted, all state frozen
//   id_opcode    opcode of the instruction in ID
//   id_cond      condition field of the branch in ID
//   F            {N, V, Z} to branch/PC control
//   flag_hazard  ID branch must stall one cycle (FORWARD = 0 only)
//   flags_q      raw registered {N, V, Z}
//
// Handshake note: there is no valid/ready pair here. A flag write happens when
// ex_valid is high and none of rst/stall/flush/hlt is asserted. The write is
// visible on flags_q one cycle later.
// -----------------------------------------------------------------------------
module flag_unit #(
    parameter logic FORWARD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [3:0]  ex_opcode,
    input  logic [15:0] alu_result,
    input  logic        alu_ovfl,
    input  logic        alu_neg,
    input  logic        stall,
    input  logic        flush,
    input  logic        hlt,
    input  logic [3:0]  id_opcode,
    input  logic [2:0]  id_cond,
    output logic [2:0]  F,
    output logic        flag_hazard,
    output logic [2:0]  flags_q
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;

    localparam logic [2:0] COND_ALWAYS = 3'b111;

    logic       wr_nvz;       // EX opcode writes N, V and Z
    logic       wr_z;         // EX opcode writes Z only
    logic       wr_class;     // EX opcode writes any flag
    logic       wr_en;
    logic       z_new;
    logic [2:0] flags_merged; // flags_q with this opcode's write class applied
    logic [2:0] flags_d;
    logic       id_cond_branch;
    logic       hazard_raw;

    // Write-class decode
    always_comb begin
        wr_nvz = 1'b0;
        wr_z   = 1'b0;
        case (ex_opcode)
            OP_ADD, OP_SUB:                 wr_nvz = 1'b1;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: wr_z   = 1'b1;
            default: begin
                wr_nvz = 1'b0;
                wr_z   = 1'b0;
            end
        endcase
    end

    assign wr_class = wr_nvz | wr_z;
    assign z_new    = (alu_result == 16'h0000);

    // rst is included so that nothing writes, and nothing is bypassed onto F,
    // while reset is held.
    assign wr_en = ex_valid & wr_class & ~stall & ~flush & ~hlt & ~rst;

    // Flags outside the write class keep their registered value.
    always_comb begin
        flags_merged = flags_q;
        if (wr_nvz) begin
            flags_merged = {alu_neg, alu_ovfl, z_new};
        end else if (wr_z) begin
            flags_merged = {flags_q[2], flags_q[1], z_new};
        end
    end

    assign flags_d = wr_en ? flags_merged : flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Unconditional branches (cond 111) never depend on flags.
    assign id_cond_branch = ((id_opcode == OP_B) || (id_opcode == OP_BR)) &&
                            (id_cond != COND_ALWAYS);

    // The hazard ignores stall and hlt. Holding the ID branch while the pipe
    // is frozen costs nothing and keeps this path simple.
    assign hazard_raw = id_cond_branch & ex_valid & ~flush & wr_class;

    // flags_d equals flags_q whenever there is no write, so with bypass
    // enabled F is simply the next-state value.
    assign F           = FORWARD ? flags_d : flags_q;
    assign flag_hazard = FORWARD ? 1'b0 : hazard_raw;

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] alu_result;
  logic        alu_ovfl;
  logic        alu_neg;
  logic        stall;
  logic        flush;
  logic        hlt;
  logic [3:0]  id_opcode;
  logic [2:0]  id_cond;

  logic [2:0]  f_fw;
  logic        hz_fw;
  logic [2:0]  fq_fw;
  logic [2:0]  f_nf;
  logic        hz_nf;
  logic [2:0]  fq_nf;

  int checks;
  int errors;

  localparam logic [3:0] ADD    = 4'b0000;
  localparam logic [3:0] SUB    = 4'b0001;
  localparam logic [3:0] XOR_OP = 4'b0010;
  localparam logic [3:0] RED    = 4'b0011;
  localparam logic [3:0] SRA    = 4'b0101;
  localparam logic [3:0] PADDSB = 4'b0111;
  localparam logic [3:0] LW     = 4'b1000;
  localparam logic [3:0] BR_B   = 4'b1100;

  flag_unit #(.FORWARD(1'b1)) dut_fw (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_opcode   (ex_opcode),
    .alu_result  (alu_result),
    .alu_ovfl    (alu_ovfl),
    .alu_neg     (alu_neg),
    .stall       (stall),
    .flush       (flush),
    .hlt         (hlt),
    .id_opcode   (id_opcode),
    .id_cond     (id_cond),
    .F           (f_fw),
    .flag_hazard (hz_fw),
    .flags_q     (fq_fw)
  );

  flag_unit #(.FORWARD(1'b0)) dut_nf (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_opcode   (ex_opcode),
    .alu_result  (alu_result),
    .alu_ovfl    (alu_ovfl),
    .alu_neg     (alu_neg),
    .stall       (stall),
    .flush       (flush),
    .hlt         (hlt),
    .id_opcode   (id_opcode),
    .id_cond     (id_cond),
    .F           (f_nf),
    .flag_hazard (hz_nf),
    .flags_q     (fq_nf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [3:0] op, input logic [15:0] res,
                          input logic neg, input logic ovf);
    ex_valid   = v;
    ex_opcode  = op;
    alu_result = res;
    alu_neg    = neg;
    alu_ovfl   = ovf;
  endtask

  task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    stall     = 1'b0;
    flush     = 1'b0;
    hlt       = 1'b0;
    id_opcode = LW;
    id_cond   = 3'b000;
    // ADD with zero result and N,V set would give 111 if it were allowed to write
    drive_ex(1'b1, ADD, 16'h0000, 1'b1, 1'b1);

    // reset held for two cycles
    step();
    check3("rst1_fq_fw", fq_fw, 3'b000);
    check3("rst1_fq_nf", fq_nf, 3'b000);
    check3("rst1_f_fw", f_fw, 3'b000);
    step();
    check3("rst2_fq_fw", fq_fw, 3'b000);
    check3("rst2_fq_nf", fq_nf, 3'b000);
    check3("rst2_f_fw", f_fw, 3'b000);

    // basic ADD: Z=1, V=1, N=0 -> 011
    rst = 1'b0;
    drive_ex(1'b1, ADD, 16'h0000, 1'b0, 1'b1);
    #1;
    check3("add_f_fw_bypass", f_fw, 3'b011);
    check3("add_f_nf_reg", f_nf, 3'b000);
    step();
    check3("add_fq_fw", fq_fw, 3'b011);
    check3("add_fq_nf", fq_nf, 3'b011);

    // XOR nonzero: N,V kept, Z cleared -> 010
    drive_ex(1'b1, XOR_OP, 16'h0005, 1'b1, 1'b0);
    step();
    check3("xor_fq_fw", fq_fw, 3'b010);
    check3("xor_f_nf", f_nf, 3'b010);

    // set up 101 for the non-writer checks
    drive_ex(1'b1, ADD, 16'h0000, 1'b1, 1'b0);
    step();
    check3("set101_fq", fq_fw, 3'b101);

    // non-writers leave flags alone
    drive_ex(1'b1, LW, 16'h0000, 1'b0, 1'b1);
    step();
    check3("lw_fq", fq_fw, 3'b101);
    drive_ex(1'b1, PADDSB, 16'h0000, 1'b0, 1'b1);
    step();
    check3("paddsb_fq", fq_nf, 3'b101);
    drive_ex(1'b1, RED, 16'h0000, 1'b0, 1'b0);
    #1;
    check3("red_f_fw", f_fw, 3'b101);
    step();
    check3("red_fq", fq_fw, 3'b101);

    // suppressed SUB (would give 100)
    drive_ex(1'b1, SUB, 16'h0005, 1'b1, 1'b0);
    stall = 1'b1;
    #1;
    check3("stall_f_fw", f_fw, 3'b101);
    step();
    check3("stall_fq", fq_fw, 3'b101);
    stall = 1'b0;
    flush = 1'b1;
    step();
    check3("flush_fq", fq_fw, 3'b101);
    flush = 1'b0;
    hlt   = 1'b1;
    #1;
    check3("hlt_f_fw", f_fw, 3'b101);
    step();
    check3("hlt_fq", fq_fw, 3'b101);
    check3("hlt_fq_nf", fq_nf, 3'b101);
    hlt = 1'b0;
    step();
    check3("sub_release_fq", fq_fw, 3'b100);

    // simultaneous stall and flush: no write (SUB zero would give 001)
    drive_ex(1'b1, SUB, 16'h0000, 1'b0, 1'b0);
    stall = 1'b1;
    flush = 1'b1;
    step();
    check3("stall_flush_fq", fq_fw, 3'b100);
    stall = 1'b0;
    flush = 1'b0;

    // bypass and hazard: SUB zero in EX, conditional B in ID
    drive_ex(1'b1, SUB, 16'h0000, 1'b0, 1'b0);
    id_opcode = BR_B;
    id_cond   = 3'b001;
    #1;
    check3("byp_f_fw", f_fw, 3'b001);
    check1("byp_hz_fw", hz_fw, 1'b0);
    check1("haz_hz_nf", hz_nf, 1'b1);
    check3("haz_f_nf_old", f_nf, 3'b100);
    // hazard ignores stall
    stall = 1'b1;
    #1;
    check1("haz_stall_hz_nf", hz_nf, 1'b1);
    stall = 1'b0;
    // flush squashes the dependency
    flush = 1'b1;
    #1;
    check1("haz_flush_hz_nf", hz_nf, 1'b0);
    flush = 1'b0;
    step();
    // bubble in EX, branch still waiting in ID
    drive_ex(1'b0, LW, 16'h1234, 1'b0, 1'b0);
    #1;
    check1("haz_clear_hz_nf", hz_nf, 1'b0);
    check3("haz_clear_f_nf", f_nf, 3'b001);
    check3("haz_clear_f_fw", f_fw, 3'b001);

    // unconditional branch: never a hazard (SUB zero with N,V set -> 111)
    id_cond = 3'b111;
    drive_ex(1'b1, SUB, 16'h0000, 1'b1, 1'b1);
    #1;
    check1("uncond_hz_nf", hz_nf, 1'b0);
    step();
    drive_ex(1'b0, LW, 16'h0000, 1'b0, 1'b0);
    #1;
    check1("uncond_bubble_hz_nf", hz_nf, 1'b0);
    check3("uncond_fq_nf", fq_nf, 3'b111);

    // Z-only writer with a conditional branch in ID also raises the hazard
    id_cond = 3'b010;
    drive_ex(1'b1, SRA, 16'h0001, 1'b0, 1'b0);
    #1;
    check1("sra_hz_nf", hz_nf, 1'b1);
    id_opcode = LW;
    #1;
    check1("nonbranch_hz_nf", hz_nf, 1'b0);

    // back-to-back: ADD 0x8000 (N=1,V=1,Z=0) then SRA zero keeps N,V -> 111
    drive_ex(1'b1, ADD, 16'h8000, 1'b1, 1'b1);
    step();
    check3("b2b_add_fq", fq_fw, 3'b110);
    drive_ex(1'b1, SRA, 16'h0000, 1'b0, 1'b0);
    step();
    check3("b2b_sra_fq", fq_fw, 3'b111);
    check3("b2b_sra_fq_nf", fq_nf, 3'b111);

    // reset mid-stream discards a pending write
    drive_ex(1'b1, ADD, 16'h0000, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    check3("midrst_fq", fq_fw, 3'b000);
    check3("midrst_f_fw", f_fw, 3'b000);
    rst = 1'b0;
    drive_ex(1'b0, LW, 16'h0000, 1'b0, 1'b0);
    step();
    check3("post_rst_fq", fq_nf, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
